// File: rtl/carry_bypass_seq_ctrl.sv
// Sequences a WIDTH-bit add through one external 16-bit carry-bypass adder,
// one 16-bit slice per cycle from the LSB up, with valid/ready on both sides.
module carry_bypass_seq_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [15:0]      add_a,
    output logic [15:0]      add_b,
    output logic             add_cin,
    input  logic [15:0]      add_sum,
    input  logic             add_cout,
    output logic             busy
);

    // WIDTH must be a non-zero multiple of 16; NSLICE is derived from it.
    localparam int NSLICE = WIDTH / 16;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [IDX_W-1:0] r_idx;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [15:0]      w_a_slice;
    logic [15:0]      w_b_slice;

    assign w_run    = (r_state == ST_RUN);
    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_last   = (r_idx == IDX_W'(NSLICE - 1));

    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int s = 0; s < NSLICE; s++) begin
            if (r_idx == IDX_W'(s)) begin
                w_a_slice = r_a[16*s +: 16];
                w_b_slice = r_b[16*s +: 16];
            end
        end
    end

    // Operand lanes are gated to zero outside RUN to keep the adder quiet.
    assign add_a   = w_run ? w_a_slice : 16'h0000;
    assign add_b   = w_run ? w_b_slice : 16'h0000;
    assign add_cin = w_run ? r_carry   : 1'b0;

    // NOTE: operand and result registers are plain flops, not a memory
    // array, so they take the async reset like the rest of the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
        end else if (w_run) begin
            for (int s = 0; s < NSLICE; s++) begin
                if (r_idx == IDX_W'(s)) begin
                    r_sum[16*s +: 16] <= add_sum;
                end
            end
            r_carry <= add_cout;
            if (w_last) begin
                r_idx  <= '0;
                r_cout <= add_cout;
            end else begin
                r_idx  <= r_idx + IDX_W'(1);
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

endmodule

// File: tb/tb_carry_bypass_seq_ctrl.sv
// Bench for carry_bypass_seq_ctrl: a behavioural 16-bit adder closes the loop,
// results are scored against a queue of reference sums.
module tb_carry_bypass_seq_ctrl;

    localparam int W  = 64;
    localparam int NS = W / 16;

    logic          clk = 1'b0;
    logic          rst;

    logic          in_valid, in_ready, in_cin;
    logic [W-1:0]  in_a, in_b;
    logic          out_valid, out_ready, out_cout;
    logic [W-1:0]  out_sum;
    logic [15:0]   add_a, add_b, add_sum;
    logic          add_cin, add_cout, busy;

    logic          in_valid16, in_ready16, in_cin16;
    logic [15:0]   in_a16, in_b16;
    logic          out_valid16, out_ready16, out_cout16;
    logic [15:0]   out_sum16;
    logic [15:0]   add_a16, add_b16, add_sum16;
    logic          add_cin16, add_cout16, busy16;

    int            total = 0;
    int            bad   = 0;
    logic [W:0]    exp_q[$];

    always #5 clk = ~clk;

    carry_bypass_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .busy(busy)
    );

    carry_bypass_seq_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16), .in_cin(in_cin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_sum(out_sum16), .out_cout(out_cout16),
        .add_a(add_a16), .add_b(add_b16), .add_cin(add_cin16),
        .add_sum(add_sum16), .add_cout(add_cout16),
        .busy(busy16)
    );

    // Stand-ins for the combinational adder macro.
    assign {add_cout, add_sum}     = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);
    assign {add_cout16, add_sum16} = {1'b0, add_a16} + {1'b0, add_b16} + 17'(add_cin16);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Scoreboard: one result pops for every output handshake.
    always @(negedge clk) begin : monitor
        logic [W:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("result", {out_cout, out_sum}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Issues one op, returns add_cin per RUN cycle and OR of all add_a/add_b.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output logic [3:0] cin_seen, output logic [15:0] ab_or);
        int n = 0;
        wait_ready();
        in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
        tick();
        exp_q.push_back(ref_add(a, b, c));
        in_valid = 1'b0;
        cin_seen = '0;
        ab_or    = '0;
        while (!out_valid && n < 20) begin
            if (n < 4) cin_seen[n] = add_cin;
            ab_or = ab_or | add_a | add_b;
            tick();
            n++;
        end
        check("latency", n, NS);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [3:0]  cs;
        logic [15:0] ab;
        logic [W:0]  hold_exp;
        logic        seen;
        logic        rdy;
        int          accepts, cyc, last;

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
        in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_cin16 = 1'b0; out_ready16 = 1'b1;
        repeat (3) tick();

        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_add", {add_a, add_b, add_cin}, 0);
        check("rst16_state", {out_valid16, in_ready16, busy16}, 3'b010);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        // All-ones plus one: carry ripples through every slice.
        run_op({W{1'b1}}, 64'h1, 1'b0, cs, ab);
        check("ones_add_cin_seq", cs, 4'b1110);
        check("done_add_gated", {add_a, add_b, add_cin}, 0);
        drain();

        // Zero operands with carry-in only.
        run_op('0, '0, 1'b1, cs, ab);
        check("zero_add_ab", ab, 0);
        check("zero_add_cin_seq", cs, 4'b0001);
        drain();

        // Stall in DONE while the input side thrashes.
        out_ready = 1'b0;
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, cs, ab);
        hold_exp = ref_add(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            in_a = {$urandom, $urandom};
            in_b = {$urandom, $urandom};
            tick();
            check("hold_out_valid", out_valid, 1);
            check("hold_result", {out_cout, out_sum}, hold_exp);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("hold_release_idle", busy, 0);
        tick();
        check("hold_no_accept", busy, 0);
        check("hold_queue_empty", exp_q.size(), 0);

        // Abort in the second RUN cycle.
        wait_ready();
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("abort_in_run", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;
        #1;
        check("abort_add_zero", {add_a, add_b, add_cin}, 0);
        check("abort_release_ready", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | out_valid;
        end
        check("abort_no_out_valid", seen, 0);
        run_op(64'd5, 64'd7, 1'b0, cs, ab);
        check("after_abort_sum", out_sum, 64'd12);
        drain();

        // Back-to-back random ops with both handshakes held open.
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom}; in_cin = 1'($urandom);
        accepts = 0; cyc = 0; last = -1;
        while (accepts < 1000 && cyc < 7000) begin
            rdy = in_ready;
            tick();
            cyc++;
            if (rdy) begin
                exp_q.push_back(ref_add(in_a, in_b, in_cin));
                if (last >= 0) check("accept_spacing", cyc - last, NS + 2);
                last = cyc;
                accepts++;
                in_a = {$urandom, $urandom};
                in_b = {$urandom, $urandom};
                in_cin = 1'($urandom);
            end
        end
        in_valid = 1'b0;
        check("random_accepts", accepts, 1000);
        drain();

        // Single-slice instance.
        check("w16_ready", in_ready16, 1);
        in_a16 = 16'h8000; in_b16 = 16'h8000; in_cin16 = 1'b1; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        check("w16_run_add_cin", {out_valid16, add_cin16}, 2'b01);
        tick();
        check("w16_out_valid", out_valid16, 1);
        check("w16_out_sum", out_sum16, 16'h0001);
        check("w16_out_cout", out_cout16, 1);
        tick();
        check("w16_back_idle", {busy16, in_ready16}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
